// File: rtl/cpu_ocimem_arbiter.sv
// cpu_ocimem_arbiter: round-robin JTAG/CPU sequencer for the single-port OCIMEM debug RAM.
// Define OCIMEM_AUTOINC_EN to post-increment the JTAG address after every JTAG read or write.
module cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_rdy,
  output logic              jtag_overrun
);
  typedef enum logic [2:0] {IDLE, CPU_WR, CPU_RD, CPU_RACK, J_WR, J_RD, J_RACK} state_t;
  state_t state, state_nxt;
  logic pending, pend_wr, last_jtag, strobe, accept, load_a, cpu_req, grant_j, done_j, step, cpu_side;
  logic [ADDR_W-1:0] jaddr;
  logic [31:0] pend_data, cpu_rd_q, mon_q;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  assign strobe  = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
  assign accept  = strobe && jtag_rdy;
  assign load_a  = accept && take_action_ocimem_a && !take_action_ocimem_b;
  assign cpu_req = cpu_read || cpu_write;
  assign grant_j = pending && (!cpu_req || !last_jtag);
  assign done_j  = state == J_WR || state == J_RACK;
`ifdef OCIMEM_AUTOINC_EN
  assign step = done_j;
`else
  assign step = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE   ? (grant_j ? (pend_wr ? J_WR : J_RD) :
                                   cpu_req ? (cpu_write ? CPU_WR : CPU_RD) : IDLE) :
                state == CPU_RD ? CPU_RACK :
                state == J_RD   ? J_RACK : IDLE;
  end
  // Read data is forwarded during the RACK cycle so it is valid while waitrequest is low.
  always_comb begin
    cpu_side        = state == CPU_WR || state == CPU_RD || state == CPU_RACK;
    ram_wren        = state == CPU_WR || state == J_WR;
    ram_addr        = cpu_side ? cpu_address : jaddr;
    ram_wdata       = state == CPU_WR ? cpu_writedata : state == J_WR ? pend_data : '0;
    cpu_waitrequest = !(state == CPU_WR || state == CPU_RACK);
    cpu_readdata    = state == CPU_RACK ? ram_rdata : cpu_rd_q;
    MonDReg         = state == J_RACK ? ram_rdata : mon_q;
    jtag_rdy        = !pending || done_j;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending      <= 1'b0;
      pend_wr      <= 1'b0;
      pend_data    <= '0;
      jaddr        <= '0;
      last_jtag    <= 1'b0;
      jtag_overrun <= 1'b0;
      cpu_rd_q     <= '0;
      mon_q        <= '0;
    end else begin
      pending      <= accept || (pending && !done_j);
      jaddr        <= load_a ? jdo[ADDR_W+16:17] : step ? ADDR_W'(jaddr + 1'b1) : jaddr;
      jtag_overrun <= load_a ? 1'b0 : jtag_overrun || (strobe && !jtag_rdy);
      if (accept) pend_wr <= take_action_ocimem_b;
      if (accept && take_action_ocimem_b) pend_data <= jdo[34:3];
      if (state == IDLE && (grant_j || cpu_req)) last_jtag <= grant_j;
      if (state == CPU_RACK) cpu_rd_q <= ram_rdata;
      if (state == J_RACK) mon_q <= ram_rdata;
    end
endmodule

// File: doc/cpu_ocimem_arbiter.md
Name: cpu_ocimem_arbiter

Overview:
- Sequences and arbitrates the CPU's on-chip debug memory (OCIMEM), a single-port RAM of 2^ADDR_W x 32.
- Two requesters share the RAM: the JTAG debug path (take_action_ocimem_*/jdo strobes from the JTAG debug module) and the CPU's Avalon-style monitor slave port.
- JTAG reads return data on MonDReg for capture into the JTAG shift register; jtag_rdy feeds monitor_ready.

Parameters:
- ADDR_W, 8, OCIMEM address width; legal range 1..17.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- take_action_ocimem_a  in  1  JTAG pulse: load address from jdo[ADDR_W+16:17], then read
- take_no_action_ocimem_a  in  1  JTAG pulse: read at current address
- take_action_ocimem_b  in  1  JTAG pulse: write jdo[34:3] at current address
- jdo  in  38  JTAG update-DR data
- cpu_address  in  ADDR_W  CPU word address
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_writedata  in  32  CPU write data
- cpu_readdata  out  32  CPU read data, valid when cpu_waitrequest is low after a read
- cpu_waitrequest  out  1  high = CPU must hold its request
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; 1-cycle registered latency
- MonDReg  out  32  last JTAG read data
- jtag_rdy  out  1  high = no JTAG command pending or executing
- jtag_overrun  out  1  sticky: a JTAG command was dropped

Behaviour:
- Reset values: state IDLE; jtag address 0; pending 0; last_grant = CPU; MonDReg 0; cpu_readdata 0; cpu_waitrequest 1; ram_wren 0; ram_addr 0; ram_wdata 0; jtag_rdy 1; jtag_overrun 0.
- Reset mid-operation aborts immediately. ram_wren falls asynchronously and no later write occurs.
- JTAG capture: a strobe while jtag_rdy=1 registers the command type, address and data into a one-deep pending slot; jtag_rdy falls the next cycle.
- Priority among simultaneous strobes: b > a > no_action_a.
- Strobe while jtag_rdy=0: the command is dropped and jtag_overrun is set.
- jtag_overrun clears when a take_action_ocimem_a is accepted; an accepted command wins over the sticky set.
- CPU request: cpu_read or cpu_write seen in IDLE. If both are high, write wins.
- Arbitration happens in IDLE only and is round-robin:
  - both requesting: grant the side opposite last_grant, then update last_grant;
  - single requester: grant it. After reset, JTAG wins the first contention.
- FSM states:
  - IDLE: pick a grant.
  - CPU_WR: ram_wren=1, ram_addr=cpu_address, cpu_waitrequest=0 for that one cycle; go to IDLE.
  - CPU_RD: ram_addr=cpu_address; go to CPU_RACK.
  - CPU_RACK: cpu_readdata<=ram_rdata, cpu_waitrequest=0 this cycle; go to IDLE.
  - J_WR: ram_wren=1 with the pending data; increment address; clear pending; go to IDLE.
  - J_RD: issue address; go to J_RACK.
  - J_RACK: MonDReg<=ram_rdata; increment address; clear pending; go to IDLE.
- cpu_waitrequest is high in every state except CPU_WR and CPU_RACK. It is decoded from the state register only.
- Latency (uncontended, request in cycle N): write completes in N+1; read data is valid with waitrequest low in N+2.
- JTAG latency: strobe in N, pending set N+1; MonDReg valid and jtag_rdy high in N+3 (read) or N+2 (write).
- take_action_ocimem_a loads the address before the read is issued, so the read uses the new address.
- Address increment wraps 2^ADDR_W-1 -> 0.
- ram_wren is never high outside CPU_WR and J_WR. No back-to-back grant to one side while the other is waiting.

Optional Feature:
- Macro OCIMEM_AUTOINC_EN.
- Defined: the JTAG address post-increments after every JTAG read or write, with wrap as above.
- Undefined: the JTAG address changes only on take_action_ocimem_a; repeated reads and writes hit the same word.
- The CPU side is unaffected in both cases.

Test Plan:
- Reset, then ocimem_b with jdo[34:3]=0xDEADBEEF at address 0 -> RAM[0]=0xDEADBEEF. Then ocimem_a with address 0 -> MonDReg=0xDEADBEEF and jtag_rdy high 3 cycles after the strobe.
- CPU writes 0x12345678 to 0x05, then reads 0x05 -> waitrequest low 1 cycle after the write; readdata=0x12345678 with waitrequest low 2 cycles after the read starts.
- JTAG strobe and CPU read in the same cycle after reset -> JTAG granted first and the CPU held; next contention grants the CPU.
- Second JTAG strobe 1 cycle after the first -> the second is dropped and jtag_overrun=1; a following accepted ocimem_a clears it.
- AUTOINC defined: address 0xFF loaded, then two no_action_a reads -> reads RAM[0xFF], RAM[0x00], RAM[0x01]. AUTOINC undefined: all reads return RAM[0xFF].
- Assert reset during J_WR -> ram_wren falls immediately, RAM is unchanged, and all outputs return to their reset values.
